// File: rtl/lag_pl_out_alloc.sv
// Physical-lane output allocator for a LAG output port: binds requesters to free
// lanes round-robin, holds each binding until the tail flit, and gates flits on lane credit.
module lag_pl_out_alloc #(
    parameter int num_reqs      = 4,
    parameter int num_pls       = 4,
    parameter int require_empty = 1,
    parameter int pl_id_bits    = (num_pls > 1) ? $clog2(num_pls) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [num_reqs-1:0]            req,
    input  logic [num_reqs-1:0]            req_flit_valid,
    input  logic [num_reqs-1:0]            req_tail,
    input  logic [num_pls-1:0]             pl_status,
    input  logic [num_pls-1:0]             pl_empty,
    output logic [num_reqs-1:0]            bound,
    output logic [num_reqs*pl_id_bits-1:0] bound_pl,
    output logic [num_reqs-1:0]            flit_sent,
    output logic [num_pls-1:0]             flits_valid,
    output logic [num_pls-1:0]             pl_busy
);

    localparam int rid_bits = (num_reqs > 1) ? $clog2(num_reqs) : 1;

    typedef enum logic {REQ_IDLE, REQ_BOUND} req_state_t;
    typedef enum logic {PL_FREE, PL_BOUND} pl_state_t;

    req_state_t            req_state_q [num_reqs];
    req_state_t            req_state_d [num_reqs];
    logic [pl_id_bits-1:0] req_lane_q  [num_reqs];
    logic [pl_id_bits-1:0] req_lane_d  [num_reqs];
    pl_state_t             pl_state_q  [num_pls];
    pl_state_t             pl_state_d  [num_pls];
    logic [rid_bits-1:0]   pl_owner_q  [num_pls];
    logic [rid_bits-1:0]   pl_owner_d  [num_pls];
    logic [rid_bits-1:0]   rr_ptr;
    logic [rid_bits-1:0]   rr_ptr_d;

    logic [num_reqs-1:0]   cand;
    logic [num_pls-1:0]    elig;
    logic                  win_found;
    logic [rid_bits-1:0]   win_idx;
    logic                  lane_found;
    logic [pl_id_bits-1:0] lane_idx;
    logic                  grant;

    // Handshake: req_flit_valid[r] is the offer, flit_sent[r] is the same-cycle accept;
    // a flit moves only when both are high, and the requester pops it on flit_sent.
    always_comb begin
        flit_sent = '0;
        for (int r = 0; r < num_reqs; r++) begin
            if (req_state_q[r] == REQ_BOUND && req_flit_valid[r] && !pl_status[req_lane_q[r]])
                flit_sent[r] = 1'b1;
        end
    end

    always_comb begin
        flits_valid = '0;
        for (int p = 0; p < num_pls; p++) begin
            if (pl_state_q[p] == PL_BOUND && flit_sent[pl_owner_q[p]])
                flits_valid[p] = 1'b1;
        end
    end

    // Candidates and eligible lanes use registered state only, so anything
    // released this cycle is not reusable until the next one.
    always_comb begin
        cand = '0;
        for (int r = 0; r < num_reqs; r++)
            cand[r] = req[r] && (req_state_q[r] == REQ_IDLE);
        elig = '0;
        for (int p = 0; p < num_pls; p++)
            elig[p] = (pl_state_q[p] == PL_FREE) && !pl_status[p] &&
                      ((require_empty == 0) || pl_empty[p]);
    end

    always_comb begin
        int cidx;
        cidx      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < num_reqs; i++) begin
            cidx = (int'(rr_ptr) + i) % num_reqs;
            if (!win_found && cand[cidx]) begin
                win_found = 1'b1;
                win_idx   = rid_bits'(cidx);
            end
        end
    end

    always_comb begin
        lane_found = 1'b0;
        lane_idx   = '0;
        for (int p = 0; p < num_pls; p++) begin
            if (!lane_found && elig[p]) begin
                lane_found = 1'b1;
                lane_idx   = pl_id_bits'(p);
            end
        end
    end

    assign grant = win_found && lane_found;

    // Release and grant never touch the same entries: the winner is idle and the lane free.
    always_comb begin
        for (int r = 0; r < num_reqs; r++) begin
            req_state_d[r] = req_state_q[r];
            req_lane_d[r]  = req_lane_q[r];
        end
        for (int p = 0; p < num_pls; p++) begin
            pl_state_d[p] = pl_state_q[p];
            pl_owner_d[p] = pl_owner_q[p];
        end
        rr_ptr_d = rr_ptr;

        for (int r = 0; r < num_reqs; r++) begin
            if (flit_sent[r] && req_tail[r]) begin
                req_state_d[r]             = REQ_IDLE;
                req_lane_d[r]              = '0;
                pl_state_d[req_lane_q[r]]  = PL_FREE;
                pl_owner_d[req_lane_q[r]]  = '0;
            end
        end

        if (grant) begin
            req_state_d[win_idx] = REQ_BOUND;
            req_lane_d[win_idx]  = lane_idx;
            pl_state_d[lane_idx] = PL_BOUND;
            pl_owner_d[lane_idx] = win_idx;
            rr_ptr_d = (win_idx == rid_bits'(num_reqs - 1)) ? '0 : win_idx + rid_bits'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < num_reqs; r++) begin
                req_state_q[r] <= REQ_IDLE;
                req_lane_q[r]  <= '0;
            end
            for (int p = 0; p < num_pls; p++) begin
                pl_state_q[p] <= PL_FREE;
                pl_owner_q[p] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int r = 0; r < num_reqs; r++) begin
                req_state_q[r] <= req_state_d[r];
                req_lane_q[r]  <= req_lane_d[r];
            end
            for (int p = 0; p < num_pls; p++) begin
                pl_state_q[p] <= pl_state_d[p];
                pl_owner_q[p] <= pl_owner_d[p];
            end
            rr_ptr <= rr_ptr_d;
        end
    end

    always_comb begin
        bound    = '0;
        bound_pl = '0;
        pl_busy  = '0;
        for (int r = 0; r < num_reqs; r++) begin
            bound[r]                               = (req_state_q[r] == REQ_BOUND);
            bound_pl[r*pl_id_bits +: pl_id_bits]   = req_lane_q[r];
        end
        for (int p = 0; p < num_pls; p++)
            pl_busy[p] = (pl_state_q[p] == PL_BOUND);
    end

endmodule

// File: tb/tb_lag_pl_out_alloc.sv
// Directed bench for lag_pl_out_alloc: allocation order, credit gating,
// release/reuse timing with require_empty, and asynchronous reset.
module tb_lag_pl_out_alloc;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req_flit_valid;
    logic [3:0] req_tail;
    logic [3:0] pl_status;
    logic [3:0] pl_empty;
    logic [3:0] bound;
    logic [7:0] bound_pl;
    logic [3:0] flit_sent;
    logic [3:0] flits_valid;
    logic [3:0] pl_busy;

    int passed;
    int total;

    lag_pl_out_alloc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .req_flit_valid (req_flit_valid),
        .req_tail       (req_tail),
        .pl_status      (pl_status),
        .pl_empty       (pl_empty),
        .bound          (bound),
        .bound_pl       (bound_pl),
        .flit_sent      (flit_sent),
        .flits_valid    (flits_valid),
        .pl_busy        (pl_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        req            = '0;
        req_flit_valid = '0;
        req_tail       = '0;
        pl_status      = '0;
        pl_empty       = '1;
        tick;
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_bound [4];
    logic [7:0] exp_bpl   [4];
    logic [1:0] exp_rr    [4];

    initial begin
        passed = 0;
        total  = 0;
        exp_bound = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        exp_bpl   = '{8'h00, 8'h04, 8'h24, 8'hE4};
        exp_rr    = '{2'd1, 2'd2, 2'd3, 2'd0};

        // Reset held over two edges
        rst_n = 1'b0; req = '0; req_flit_valid = '0; req_tail = '0;
        pl_status = '0; pl_empty = '1;
        tick; tick;
        chk("rst_bound",    32'(bound), 32'h0);
        chk("rst_bound_pl", 32'(bound_pl), 32'h0);
        chk("rst_pl_busy",  32'(pl_busy), 32'h0);
        chk("rst_rr_ptr",   32'(dut.rr_ptr), 32'h0);

        // Basic single-flit packet
        rst_n = 1'b1;
        req = 4'b0001;
        tick;
        chk("basic_bound",    32'(bound), 32'h1);
        chk("basic_bound_pl", 32'(bound_pl), 32'h0);
        chk("basic_pl_busy",  32'(pl_busy), 32'h1);
        req = '0; req_flit_valid = 4'b0001; req_tail = 4'b0001;
        #1;
        chk("basic_flit_sent",   32'(flit_sent), 32'h1);
        chk("basic_flits_valid", 32'(flits_valid), 32'h1);
        tick;
        req_flit_valid = '0; req_tail = '0;
        #1;
        chk("basic_rel_bound",   32'(bound), 32'h0);
        chk("basic_rel_pl_busy", 32'(pl_busy), 32'h0);
        chk("basic_rel_sent",    32'(flit_sent), 32'h0);

        // Contention: four requesters, four free lanes
        do_reset;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("cont_bound",    32'(bound), 32'(exp_bound[k]));
            chk("cont_bound_pl", 32'(bound_pl), 32'(exp_bpl[k]));
            chk("cont_rr_ptr",   32'(dut.rr_ptr), 32'(exp_rr[k]));
        end
        chk("cont_pl_busy", 32'(pl_busy), 32'hF);

        // Credit stall: r2 on lane 1
        do_reset;
        req = 4'b0001;
        tick;
        req = 4'b0100;
        tick;
        chk("stall_bound",    32'(bound), 32'h5);
        chk("stall_bound_pl", 32'(bound_pl), 32'h10);
        req = '0; req_flit_valid = 4'b0100; pl_status = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_sent",  32'(flit_sent), 32'h0);
            chk("stall_valid", 32'(flits_valid), 32'h0);
            tick;
        end
        pl_status = '0;
        #1;
        chk("unstall_sent",  32'(flit_sent), 32'h4);
        chk("unstall_valid", 32'(flits_valid), 32'h2);
        req_flit_valid = 4'b0111;
        #1;
        chk("two_lane_sent",  32'(flit_sent), 32'h5);
        chk("two_lane_valid", 32'(flits_valid), 32'h3);
        tick;
        req_flit_valid = '0;
        #1;
        chk("no_tail_bound", 32'(bound), 32'h5);

        // Release and reuse, lane 2 only eligible
        do_reset;
        pl_empty = 4'b0100;
        req = 4'b0010;
        tick;
        chk("reuse_bound",    32'(bound), 32'h2);
        chk("reuse_bound_pl", 32'(bound_pl), 32'h08);
        req = 4'b1010; req_flit_valid = 4'b0010;
        #1;
        chk("reuse_f1_sent",  32'(flit_sent), 32'h2);
        chk("reuse_f1_valid", 32'(flits_valid), 32'h4);
        tick;
        chk("reuse_wait_bound", 32'(bound), 32'h2);
        #1;
        chk("reuse_f2_sent", 32'(flit_sent), 32'h2);
        tick;
        req_tail = 4'b0010; pl_empty = 4'b0000; req = 4'b1000;
        #1;
        chk("reuse_tail_sent",  32'(flit_sent), 32'h2);
        chk("reuse_tail_valid", 32'(flits_valid), 32'h4);
        tick;
        req_flit_valid = '0; req_tail = '0;
        #1;
        chk("reuse_t1_pl_busy", 32'(pl_busy), 32'h0);
        chk("reuse_t1_bound",   32'(bound), 32'h0);
        tick;
        chk("reuse_t2_bound", 32'(bound), 32'h0);
        tick;
        chk("reuse_t3_bound", 32'(bound), 32'h0);
        tick;
        pl_empty = 4'b0100;
        #1;
        chk("reuse_t4_bound", 32'(bound), 32'h0);
        tick;
        chk("reuse_t5_bound",    32'(bound), 32'h8);
        chk("reuse_t5_bound_pl", 32'(bound_pl), 32'h80);
        chk("reuse_t5_pl_busy",  32'(pl_busy), 32'h4);
        chk("reuse_t5_rr_ptr",   32'(dut.rr_ptr), 32'h0);

        // No free lane: lane 3 never eligible, lanes 0..2 taken by r1..r3
        do_reset;
        pl_empty = 4'b0111;
        req = 4'b1110;
        tick;
        chk("full_b1", 32'(bound), 32'h2);
        tick;
        chk("full_b2", 32'(bound), 32'h6);
        tick;
        chk("full_b3", 32'(bound), 32'hE);
        req = 4'b0001;
        tick;
        chk("full_wait_bound", 32'(bound), 32'hE);
        chk("full_wait_rr",    32'(dut.rr_ptr), 32'h0);
        tick;
        chk("full_wait2_bound", 32'(bound), 32'hE);
        req_flit_valid = 4'b0100; req_tail = 4'b0100;
        #1;
        chk("full_tail_sent",  32'(flit_sent), 32'h4);
        chk("full_tail_valid", 32'(flits_valid), 32'h2);
        tick;
        req_flit_valid = '0; req_tail = '0;
        #1;
        chk("full_rel_bound",    32'(bound), 32'hA);
        chk("full_rel_pl_busy",  32'(pl_busy), 32'h5);
        chk("full_rel_bound_pl", 32'(bound_pl), 32'h80);
        tick;
        chk("full_grant_bound",    32'(bound), 32'hB);
        chk("full_grant_bound_pl", 32'(bound_pl), 32'h81);
        chk("full_grant_rr",       32'(dut.rr_ptr), 32'h1);
        chk("full_grant_pl_busy",  32'(pl_busy), 32'h7);

        // Asynchronous reset mid-packet with three lanes bound
        req = '0; req_flit_valid = 4'b1011;
        #1;
        chk("arst_pre_sent",  32'(flit_sent), 32'hB);
        chk("arst_pre_valid", 32'(flits_valid), 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_bound",    32'(bound), 32'h0);
        chk("arst_bound_pl", 32'(bound_pl), 32'h0);
        chk("arst_pl_busy",  32'(pl_busy), 32'h0);
        chk("arst_sent",     32'(flit_sent), 32'h0);
        chk("arst_valid",    32'(flits_valid), 32'h0);
        #2;
        rst_n = 1'b1; req_flit_valid = '0; pl_empty = '1; req = 4'b0100;
        tick;
        chk("arst_new_bound",    32'(bound), 32'h4);
        chk("arst_new_bound_pl", 32'(bound_pl), 32'h00);
        chk("arst_new_pl_busy",  32'(pl_busy), 32'h1);
        chk("arst_new_rr",       32'(dut.rr_ptr), 32'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
